// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample averaging / bar-graph display path.
// Holds the default sample width, LED bar width, channel count, the channel
// index type and the averager FSM state encoding.
package adc_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned NUM_CH = 8;

  typedef logic [$clog2(NUM_CH)-1:0] ch_t;

  // EMPTY: no average since reset or since the last channel selection change.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/adc_led_bar.sv
// Registered thermometer bar with peak-hold dot.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   avg        : window average (DATA_W bits) driving the bar length
//   peak       : peak-hold value; its top 3 bits select the dot position
//   empty      : blanks the display when no average exists yet
//   led        : registered LED pattern (LED_W bits)
module adc_led_bar
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] avg,
  input  logic [DATA_W-1:0] peak,
  input  logic              empty,
  output logic [LED_W-1:0]  led
);

  // Round to the nearest 1/8 of full scale: add half a step, keep the top 4 bits.
  localparam logic [DATA_W:0] HALF_STEP = (DATA_W + 1)'(1) << (DATA_W - 4);

  logic [DATA_W:0]  rounded;
  logic [3:0]       lit_raw;
  logic [3:0]       lit;
  logic [LED_W-1:0] bar;
  logic [LED_W-1:0] led_d;
  logic [LED_W-1:0] led_q;

  always_comb begin
    rounded = {1'b0, avg} + HALF_STEP;
    lit_raw = rounded[DATA_W -: 4];
    lit     = (lit_raw > 4'd8) ? 4'd8 : lit_raw;

    bar = '0;
    for (int k = 0; k < int'(LED_W); k++) begin
      if (k < int'(lit)) bar[k] = 1'b1;
    end
    if (peak != '0) bar[peak[DATA_W-1 -: 3]] = 1'b1;

    led_d = empty ? '0 : bar;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= led_d;
  end

  assign led = led_q;

endmodule

// File: rtl/adc_avg_bargraph.sv
// Block averager with decaying peak hold and LED bar readout for one selected
// ADC channel.
// Ports:
//   iCLK, iRST  : clock (rising edge) and asynchronous active-low reset
//   iVALID      : one-cycle strobe qualifying iDATA / iCH
//   iDATA, iCH  : conversion result and the channel it belongs to
//   iSEL        : channel to monitor; a change restarts averaging
//   oAVG        : latest window average, oAVG_VALID pulses when it updates
//   oPEAK       : decaying peak-hold of window averages
//   oLED        : thermometer bar plus peak dot, one cycle behind oAVG
module adc_avg_bargraph #(
  parameter int unsigned DATA_W = adc_pkg::DATA_W,
  parameter int unsigned LOG2_N = 4,
  parameter int unsigned DECAY  = 64
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVALID,
  input  logic [DATA_W-1:0] iDATA,
  input  logic [2:0]        iCH,
  input  logic [2:0]        iSEL,
  output logic [DATA_W-1:0] oAVG,
  output logic              oAVG_VALID,
  output logic [DATA_W-1:0] oPEAK,
  output logic [7:0]        oLED
);

  import adc_pkg::*;

  localparam int unsigned    ACC_W   = DATA_W + LOG2_N;
  localparam logic [DATA_W-1:0] DECAY_V = DATA_W'(DECAY);

  state_t              state_q, state_d;
  ch_t                 sel_q, sel_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   avg_q, avg_d;
  logic [DATA_W-1:0]   peak_q, peak_d;
  logic                avg_valid_q, avg_valid_d;

  logic                sel_change;
  logic                accept;
  logic                win_done;
  logic [ACC_W-1:0]    sum;
  logic [DATA_W-1:0]   avg_new;
  logic [DATA_W-1:0]   peak_decayed;
  logic [DATA_W-1:0]   peak_new;
  logic                empty;

  // A selection change wins over any sample or window completion that cycle.
  assign sel_change = (iSEL != sel_q);
  assign accept     = iVALID && (iCH == sel_q) && !sel_change;
  assign win_done   = accept && (cnt_q == '1);

  always_comb begin
    sum          = acc_q + {{LOG2_N{1'b0}}, iDATA};
    avg_new      = sum[ACC_W-1 -: DATA_W];
    peak_decayed = (peak_q >= DECAY_V) ? (peak_q - DECAY_V) : '0;
    if (avg_new >= peak_q) begin
      peak_new = avg_new;
    end else begin
      peak_new = (peak_decayed > avg_new) ? peak_decayed : avg_new;
    end
  end

  always_comb begin
    sel_d       = sel_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    peak_d      = peak_q;
    avg_valid_d = 1'b0;
    if (sel_change) begin
      sel_d  = iSEL;
      acc_d  = '0;
      cnt_d  = '0;
      avg_d  = '0;
      peak_d = '0;
    end else if (win_done) begin
      avg_d       = avg_new;
      avg_valid_d = 1'b1;
      peak_d      = peak_new;
      acc_d       = '0;
      cnt_d       = '0;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sel_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      peak_q      <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      peak_q      <= peak_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  // FSM: state register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (!sel_change && win_done) state_d = RUN;
      RUN:   if (sel_change) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    empty = (state_q == EMPTY);
  end

  adc_led_bar #(
    .DATA_W (DATA_W)
  ) u_led_bar (
    .clk   (iCLK),
    .rst_n (iRST),
    .avg   (avg_q),
    .peak  (peak_q),
    .empty (empty),
    .led   (oLED)
  );

  assign oAVG       = avg_q;
  assign oAVG_VALID = avg_valid_q;
  assign oPEAK      = peak_q;

endmodule

// File: tb/tb_adc_avg_bargraph.sv
// Directed bench for adc_avg_bargraph: reset, averaging, filtering, peak decay,
// selection change and full-throughput streaming.
module tb_adc_avg_bargraph;

  import adc_pkg::*;

  logic        iCLK;
  logic        iRST;
  logic        iVALID;
  logic [11:0] iDATA;
  logic [2:0]  iCH;
  logic [2:0]  iSEL;
  logic [11:0] oAVG;
  logic        oAVG_VALID;
  logic [11:0] oPEAK;
  logic [7:0]  oLED;

  int total;
  int bad;
  int cyc;
  int pulses;
  int first_pulse;
  int last_pulse;

  adc_avg_bargraph #(
    .DATA_W (12),
    .LOG2_N (4),
    .DECAY  (64)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iVALID     (iVALID),
    .iDATA      (iDATA),
    .iCH        (iCH),
    .iSEL       (iSEL),
    .oAVG       (oAVG),
    .oAVG_VALID (oAVG_VALID),
    .oPEAK      (oPEAK),
    .oLED       (oLED)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, then tally pulses.
  task automatic step(input logic v, input logic [11:0] d, input logic [2:0] ch);
    iVALID = v;
    iDATA  = d;
    iCH    = ch;
    @(posedge iCLK);
    #1;
    cyc++;
    if (oAVG_VALID === 1'b1) begin
      pulses++;
      if (pulses == 1) first_pulse = cyc;
      last_pulse = cyc;
    end
  endtask

  task automatic window(input logic [11:0] d, input logic [2:0] ch);
    for (int i = 0; i < 16; i++) step(1'b1, d, ch);
  endtask

  task automatic clr_pulses();
    pulses      = 0;
    first_pulse = -1;
    last_pulse  = -1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    clr_pulses();
    iRST   = 1'b0;
    iVALID = 1'b0;
    iDATA  = '0;
    iCH    = '0;
    iSEL   = 3'd0;

    // Reset state
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_avg", 32'(oAVG), 32'h0);
    chk("rst_valid", 32'(oAVG_VALID), 32'h0);
    chk("rst_peak", 32'(oPEAK), 32'h0);
    chk("rst_led", 32'(oLED), 32'h0);
    iRST = 1'b1;
    step(1'b0, 12'h0, 3'd0);

    // One window at 0x800 on ch 0
    window(12'h800, 3'd0);
    chk("win800_avg", 32'(oAVG), 32'h800);
    step(1'b0, 12'h0, 3'd0);
    chk("win800_led", 32'(oLED), 32'h1F);

    // Reset mid-window
    for (int i = 0; i < 8; i++) step(1'b1, 12'h800, 3'd0);
    #2 iRST = 1'b0;
    #1;
    chk("midrst_avg", 32'(oAVG), 32'h0);
    chk("midrst_peak", 32'(oPEAK), 32'h0);
    chk("midrst_led", 32'(oLED), 32'h0);
    @(posedge iCLK);
    #1 iRST = 1'b1;
    clr_pulses();
    window(12'h800, 3'd0);
    chk("postrst_pulses", 32'(pulses), 32'd1);
    chk("postrst_avg", 32'(oAVG), 32'h800);

    // Averaging with truncation on ch 2
    iSEL = 3'd2;
    step(1'b0, 12'h0, 3'd2);
    clr_pulses();
    for (int i = 0; i < 16; i++) step(1'b1, (i % 2 == 0) ? 12'h000 : 12'hFFF, 3'd2);
    chk("trunc_valid", 32'(oAVG_VALID), 32'h1);
    chk("trunc_pulses", 32'(pulses), 32'd1);
    chk("trunc_avg", 32'(oAVG), 32'h7FF);
    chk("trunc_peak", 32'(oPEAK), 32'h7FF);
    step(1'b0, 12'h0, 3'd2);
    chk("trunc_valid_drop", 32'(oAVG_VALID), 32'h0);
    chk("trunc_led", 32'(oLED), 32'h0F);

    // Channel filtering: ch 1 interleaved with selected ch 3
    iSEL = 3'd3;
    step(1'b0, 12'h0, 3'd3);
    clr_pulses();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 12'hFFF, 3'd1);
      step(1'b1, 12'h100, 3'd3);
    end
    chk("filt_pulses", 32'(pulses), 32'd1);
    chk("filt_last", 32'(last_pulse), 32'(cyc));
    chk("filt_avg", 32'(oAVG), 32'h100);

    // Peak decay on ch 4
    iSEL = 3'd4;
    step(1'b0, 12'h0, 3'd4);
    window(12'hC00, 3'd4);
    chk("decay_p0", 32'(oPEAK), 32'hC00);
    window(12'h000, 3'd4);
    chk("decay_p1", 32'(oPEAK), 32'hBC0);
    chk("decay_avg1", 32'(oAVG), 32'h000);
    window(12'h000, 3'd4);
    chk("decay_p2", 32'(oPEAK), 32'hB80);
    window(12'hB70, 3'd4);
    chk("decay_clamp_avg", 32'(oPEAK), 32'hB70);
    for (int i = 0; i < 50; i++) window(12'h000, 3'd4);
    chk("decay_floor", 32'(oPEAK), 32'h000);

    // Saturating subtraction below DECAY on ch 6
    iSEL = 3'd6;
    step(1'b0, 12'h0, 3'd6);
    window(12'h050, 3'd6);
    chk("sat_p0", 32'(oPEAK), 32'h050);
    window(12'h000, 3'd6);
    chk("sat_p1", 32'(oPEAK), 32'h010);
    window(12'h000, 3'd6);
    chk("sat_p2", 32'(oPEAK), 32'h000);

    // Selection change coinciding with the final sample of a window
    iSEL = 3'd0;
    step(1'b0, 12'h0, 3'd0);
    window(12'h400, 3'd0);
    chk("selchg_pre_avg", 32'(oAVG), 32'h400);
    for (int i = 0; i < 15; i++) step(1'b1, 12'h400, 3'd0);
    clr_pulses();
    iSEL = 3'd5;
    step(1'b1, 12'h400, 3'd0);
    chk("selchg_valid", 32'(oAVG_VALID), 32'h0);
    chk("selchg_avg", 32'(oAVG), 32'h0);
    chk("selchg_peak", 32'(oPEAK), 32'h0);
    step(1'b0, 12'h0, 3'd5);
    chk("selchg_led", 32'(oLED), 32'h0);
    chk("selchg_fsm", 32'(dut.state_q), 32'(EMPTY));
    chk("selchg_pulses", 32'(pulses), 32'd0);

    // Full throughput: 64 back-to-back samples
    clr_pulses();
    begin
      int base;
      base = cyc;
      for (int i = 0; i < 64; i++) step(1'b1, 12'hFFF, 3'd5);
      chk("tput_pulses", 32'(pulses), 32'd4);
      chk("tput_first", 32'(first_pulse - base), 32'd16);
      chk("tput_last", 32'(last_pulse - base), 32'd64);
    end
    chk("tput_avg", 32'(oAVG), 32'hFFF);
    step(1'b0, 12'h0, 3'd5);
    chk("tput_led", 32'(oLED), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_avg_bargraph.md
# adc_avg_bargraph

Downstream consumer of the ADC serial controller's sample stream. Accepts 12-bit conversion results tagged with their channel, block-averages 2^LOG2_N samples of one selected channel, and holds a decaying peak. Drives an 8-LED thermometer bar with a peak dot. Replaces the raw top-8-bits LED display with a stable, averaged readout.

## Interface
- DATA_W, 12, sample width (ADC resolution)
- LOG2_N, 4, log2 of samples per averaging window (1..8)
- DECAY, 64, amount subtracted from peak on each window where new average < peak

- iCLK  in  1  system clock, rising edge
- iRST  in  1  reset, asynchronous, active-low
- iVALID  in  1  one-cycle strobe: iDATA/iCH valid
- iDATA  in  DATA_W  conversion result
- iCH  in  3  channel the result belongs to
- iSEL  in  3  channel to monitor
- oAVG  out  DATA_W  latest window average
- oAVG_VALID  out  1  one-cycle pulse when oAVG updates
- oPEAK  out  DATA_W  peak-hold value
- oLED  out  8  bar graph plus peak dot

## Operation
- Reset: all outputs 0, accumulator 0, sample count 0, registered selection sel_q = 0, FSM = EMPTY.
- FSM states:
  - EMPTY: no average produced since reset or since the last selection change.
  - RUN: at least one average produced.
  - EMPTY -> RUN on the first completed window.
  - RUN -> EMPTY on a selection change.
- Accept: iVALID && iCH == sel_q && iSEL == sel_q. Non-matching samples are ignored.
- Accumulator: DATA_W+LOG2_N bits wide, cannot overflow. Count: LOG2_N bits.
- On an accepted sample with count < 2^LOG2_N−1: acc += iDATA, count += 1.
- On an accepted sample with count == 2^LOG2_N−1:
  - oAVG <= (acc + iDATA) >> LOG2_N (truncating).
  - oAVG_VALID <= 1.
  - acc <= 0, count <= 0 (count wraps).
- Peak, evaluated on every window completion:
  - if new avg ≥ oPEAK: oPEAK <= avg;
  - else oPEAK <= max(avg, oPEAK − DECAY), saturating subtraction, never below avg.
- Selection change (iSEL != sel_q):
  - sel_q <= iSEL; acc, count, oAVG, oPEAK cleared; FSM -> EMPTY.
  - Any sample presented that same cycle is discarded.
  - A window completing on that same cycle is discarded; no oAVG_VALID pulse.
- LED bar:
  - lit = min(8, (oAVG + 256) >> 9); oLED[k] = 1 for k < lit.
  - When oPEAK != 0, oLED[oPEAK[11:9]] is additionally forced to 1.
  - In EMPTY, oLED = 0.

## Timing
- oAVG, oPEAK and oAVG_VALID are registered and update on the same edge that accepts the final sample of a window. oAVG_VALID is high for exactly that one cycle.
- oLED is registered from oAVG/oPEAK, so it lags oAVG by 1 cycle.
- Back-to-back iVALID on every cycle is supported at full throughput; there is no backpressure.
- Reset mid-window: immediate asynchronous clear; the first window after reset release starts at count 0.
- iSEL is sampled every cycle; a change takes effect on the next edge.

## Structure
- Shared package adc_pkg holds:
  - DATA_W = 12, LED_W = 8, NUM_CH = 8;
  - the channel-index typedef (3 bits);
  - the FSM state enum {EMPTY, RUN}.
- Sub-module adc_led_bar: registered thermometer + peak-dot encoder; inputs oAVG, oPEAK, empty flag; output oLED.
- All remaining logic (accept qualification, accumulator, counter, peak, FSM) lives in the top.

## Test plan
- Reset mid-window:
  - stimulus: 16 samples of 0x800 on iSEL=0, iRST pulsed low after the 8th;
  - response: all outputs 0 immediately; a subsequent 16 samples give oAVG=0x800 with a single oAVG_VALID pulse.
- Averaging with truncation:
  - stimulus: iSEL=2, 16 samples on ch 2 alternating 0x000/0xFFF (15 values of 0xFFF would misalign, so alternate 8/8);
  - response: oAVG = 0x7FF (truncated), one oAVG_VALID pulse on the 16th accept edge, oLED = 0x0F one cycle later, with the peak dot at bit 3.
- Channel filtering:
  - stimulus: interleave ch 1 samples (0xFFF) with ch 3 samples (0x100), iSEL=3;
  - response: after 16 ch 3 samples, oAVG = 0x100; ch 1 samples do not affect the count.
- Peak decay:
  - stimulus: one window at 0xC00, then windows at 0x000;
  - response: oPEAK follows 0xC00, 0xBC0, 0xB80, and so on, decrementing by 64 per window; it never goes below 0 and saturates at 0.
- Selection change with a coincident final sample:
  - stimulus: 15 samples on ch 0, then the 16th sample in the same cycle iSEL changes to 5;
  - response: no oAVG_VALID, oAVG = oPEAK = 0, oLED = 0, and the FSM is EMPTY.
- Full throughput:
  - stimulus: iVALID held high for 64 cycles at 0xFFF on the selected channel;
  - response: exactly 4 oAVG_VALID pulses, 16 cycles apart; oAVG = 0xFFF; oLED = 0xFF.
